// File: rtl/motor_pkg.sv
// Shared types and constants for the two-wheel motor driver.
package motor_pkg;

  localparam int unsigned SPD_W = 4;
  localparam int unsigned DIR_W = 4;

  localparam logic [DIR_W-1:0] DIR_STOP  = 4'b0000;
  localparam logic [DIR_W-1:0] DIR_FWD   = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_REV   = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RAMP_DN,
    ST_DEAD
  } state_t;

  // Wheel direction bits plus speed, held while a reversal completes
  typedef struct packed {
    logic             whl_l;
    logic             whl_r;
    logic [SPD_W-1:0] spd;
  } wheel_cmd_t;

  // A direction code is legal when it has at most one bit set
  function automatic logic dir_valid(input logic [DIR_W-1:0] d);
    return (d & (d - DIR_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/motor_drv_if.sv
// Command handshake carrying target speed and one-hot direction.
interface motor_drv_if;
  import motor_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SPD_W-1:0] speed_i;
  logic [DIR_W-1:0] dir_i;

  modport master (output cmd_valid, speed_i, dir_i, input cmd_ready);
  modport slave  (input cmd_valid, speed_i, dir_i, output cmd_ready);

endinterface

// File: rtl/pwm_gen.sv
// Prescaled 4-bit PWM counter shared by both wheel duty comparators.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int unsigned PRESC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SPD_W-1:0] duty_l,
  input  logic [SPD_W-1:0] duty_r,
  output logic             pwm_l,
  output logic             pwm_r
);

  localparam int unsigned PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [SPD_W-1:0] cnt;
  logic             step_c;

  assign step_c = (pre_cnt == PRE_W'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
      cnt     <= '0;
      pwm_l   <= 1'b0;
      pwm_r   <= 1'b0;
    end else begin
      if (step_c) begin
        pre_cnt <= '0;
        cnt     <= cnt + SPD_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      // Duty of N gives N high counts out of 16; 0 never goes high
      pwm_l <= (duty_l > cnt);
      pwm_r <= (duty_r > cnt);
    end
  end

endmodule

// File: rtl/motor_drv.sv
// Two-wheel motor driver: command decode, speed ramp, reversal dead time.
// MOTOR_SOFT_RAMP_EN enables gradual speed ramping; otherwise speed steps at once.
module motor_drv
  import motor_pkg::*;
#(
  parameter int unsigned PRESC    = 4,
  parameter int unsigned RAMP_CYC = 16,
  parameter int unsigned DEAD_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  motor_drv_if.slave        cmd,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned RAMP_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  state_t            state;
  logic [SPD_W-1:0]  cur_spd;
  logic [SPD_W-1:0]  tgt_spd;
  wheel_cmd_t        pend;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [DEAD_W-1:0] dead_cnt;

  logic              acc_c;
  logic              dir_ok_c;
  logic              new_l_c;
  logic              new_r_c;
  logic [SPD_W-1:0]  new_spd_c;

  assign acc_c = cmd.cmd_valid && cmd.cmd_ready;

  // Map the direction code onto wheel bits; stop/invalid keep bits, speed 0
  always_comb begin
    dir_ok_c  = 1'b1;
    new_l_c   = dir_l;
    new_r_c   = dir_r;
    new_spd_c = cmd.speed_i;
    case (cmd.dir_i)
      DIR_FWD:   begin new_l_c = 1'b1; new_r_c = 1'b1; end
      DIR_REV:   begin new_l_c = 1'b0; new_r_c = 1'b0; end
      DIR_LEFT:  begin new_l_c = 1'b0; new_r_c = 1'b1; end
      DIR_RIGHT: begin new_l_c = 1'b1; new_r_c = 1'b0; end
      default: begin
        dir_ok_c  = dir_valid(cmd.dir_i);
        new_spd_c = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cur_spd       <= '0;
      tgt_spd       <= '0;
      pend          <= '0;
      ramp_cnt      <= '0;
      dead_cnt      <= '0;
      dir_l         <= 1'b1;
      dir_r         <= 1'b1;
      busy          <= 1'b0;
      fault         <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (cur_spd == tgt_spd) begin
            ramp_cnt <= '0;
            if (cur_spd == '0) state <= ST_IDLE;
          end else begin
`ifdef MOTOR_SOFT_RAMP_EN
            if (ramp_cnt == RAMP_W'(RAMP_CYC - 1)) begin
              ramp_cnt <= '0;
              cur_spd  <= (cur_spd < tgt_spd) ? cur_spd + SPD_W'(1)
                                               : cur_spd - SPD_W'(1);
            end else begin
              ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
`else
            cur_spd <= tgt_spd;
`endif
          end

          if (acc_c) begin
            fault <= !dir_ok_c;
            if ({new_l_c, new_r_c} == {dir_l, dir_r}) begin
              tgt_spd <= new_spd_c;
              state   <= ST_RUN;
`ifdef MOTOR_SOFT_RAMP_EN
              ramp_cnt <= '0;
`else
              cur_spd  <= new_spd_c;
`endif
            end else begin
              // Wheel reversal: stash the command until the wheels are stopped
              pend          <= '{whl_l: new_l_c, whl_r: new_r_c, spd: new_spd_c};
              tgt_spd       <= '0;
              ramp_cnt      <= '0;
              dead_cnt      <= '0;
              busy          <= 1'b1;
              cmd.cmd_ready <= 1'b0;
`ifdef MOTOR_SOFT_RAMP_EN
              cur_spd <= cur_spd;
              state   <= (cur_spd != '0) ? ST_RAMP_DN : ST_DEAD;
`else
              cur_spd <= '0;
              state   <= ST_DEAD;
`endif
            end
          end
        end

        ST_RAMP_DN: begin
          if (cur_spd == '0) begin
            state    <= ST_DEAD;
            dead_cnt <= '0;
          end else if (ramp_cnt == RAMP_W'(RAMP_CYC - 1)) begin
            ramp_cnt <= '0;
            cur_spd  <= cur_spd - SPD_W'(1);
            if (cur_spd == SPD_W'(1)) begin
              state    <= ST_DEAD;
              dead_cnt <= '0;
            end
          end else begin
            ramp_cnt <= ramp_cnt + RAMP_W'(1);
          end
        end

        ST_DEAD: begin
          if (dead_cnt == DEAD_W'(DEAD_CYC - 1)) begin
            dead_cnt      <= '0;
            ramp_cnt      <= '0;
            dir_l         <= pend.whl_l;
            dir_r         <= pend.whl_r;
            tgt_spd       <= pend.spd;
`ifndef MOTOR_SOFT_RAMP_EN
            cur_spd       <= pend.spd;
`endif
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            state         <= ST_RUN;
          end else begin
            dead_cnt <= dead_cnt + DEAD_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  pwm_gen #(
    .PRESC (PRESC)
  ) u_pwm_gen (
    .clk    (clk),
    .rst    (rst),
    .duty_l (cur_spd),
    .duty_r (cur_spd),
    .pwm_l  (pwm_l),
    .pwm_r  (pwm_r)
  );

endmodule

// File: tb/tb_motor_drv.sv
// Scoreboard bench for motor_drv with PRESC=1, RAMP_CYC=2, DEAD_CYC=4.
module tb_motor_drv;
  import motor_pkg::*;

  localparam int unsigned PRESC    = 1;
  localparam int unsigned RAMP_CYC = 2;
  localparam int unsigned DEAD_CYC = 4;
`ifdef MOTOR_SOFT_RAMP_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm_l, pwm_r, dir_l, dir_r, busy, fault;

  motor_drv_if cmd_if ();

  motor_drv #(
    .PRESC    (PRESC),
    .RAMP_CYC (RAMP_CYC),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd_if.slave),
    .pwm_l (pwm_l),
    .pwm_r (pwm_r),
    .dir_l (dir_l),
    .dir_r (dir_r),
    .busy  (busy),
    .fault (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) check("ready_timeout", 0, 1);
  endtask

  // Returns just after the accepting clock edge
  task automatic send(input logic [3:0] dir, input logic [3:0] spd);
    wait_ready(200);
    cmd_if.dir_i     = dir;
    cmd_if.speed_i   = spd;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic duty(output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (16) begin
      @(negedge clk);
      hl += int'(pwm_l);
      hr += int'(pwm_r);
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
  endtask

  task automatic exp_duty(input string tag, input int d);
    int hl, hr;
    sb_push({tag, "_duty_l"}, d);
    sb_push({tag, "_duty_r"}, d);
    duty(hl, hr);
    sb_pop(hl);
    sb_pop(hr);
  endtask

  task automatic exp_dirs(input string tag, input int l, input int r);
    sb_push({tag, "_dir_l"}, l);
    sb_push({tag, "_dir_r"}, r);
    sb_pop(int'(dir_l));
    sb_pop(int'(dir_r));
  endtask

  task automatic exp_reset_vals(input string tag);
    sb_push({tag, "_pwm_l"}, 0);
    sb_push({tag, "_pwm_r"}, 0);
    sb_push({tag, "_dir_l"}, 1);
    sb_push({tag, "_dir_r"}, 1);
    sb_push({tag, "_busy"}, 0);
    sb_push({tag, "_fault"}, 0);
    sb_push({tag, "_ready"}, 1);
    sb_push({tag, "_state"}, int'(ST_IDLE));
    sb_push({tag, "_cur_spd"}, 0);
    sb_pop(int'(pwm_l));
    sb_pop(int'(pwm_r));
    sb_pop(int'(dir_l));
    sb_pop(int'(dir_r));
    sb_pop(int'(busy));
    sb_pop(int'(fault));
    sb_pop(int'(cmd_if.cmd_ready));
    sb_pop(int'(dut.state));
    sb_pop(int'(dut.cur_spd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, hi, n;
    bit pd;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.speed_i   = '0;
    cmd_if.dir_i     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_reset_vals("rst");
    rst = 1'b1;
    sb_push("ready_after_rst", 1);
    @(negedge clk);
    sb_pop(int'(cmd_if.cmd_ready));

    // Forward 8: ramp timing, wheel bits, 8/16 duty
    sb_push("fwd8_spd_at15", SOFT ? 7 : 8);
    sb_push("fwd8_spd_at16", 8);
    send(DIR_FWD, 4'd8);
    repeat (15) @(posedge clk);
    #1 sb_pop(int'(dut.cur_spd));
    @(posedge clk);
    #1 sb_pop(int'(dut.cur_spd));
    exp_dirs("fwd8", 1, 1);
    exp_duty("fwd8", 8);

    send(DIR_FWD, 4'd15);
    settle();
    exp_duty("fwd15", 15);

    send(DIR_FWD, 4'd0);
    settle();
    exp_duty("fwd0", 0);
    sb_push("fwd0_state", int'(ST_IDLE));
    sb_pop(int'(dut.state));

    send(DIR_FWD, 4'd8);
    settle();

    // Reversal to rev 5
    sb_push("rev_ready", 0);
    sb_push("rev_busy", 1);
    sb_push("rev_busy_cyc", SOFT ? 20 : 4);
    sb_push("rev_dead_cyc", int'(DEAD_CYC));
    sb_push("rev_dead_pwm", 0);
    sb_push("rev_ready_back", 1);
    send(DIR_REV, 4'd5);
    @(negedge clk);
    sb_pop(int'(cmd_if.cmd_ready));
    sb_pop(int'(busy));
    nb = 0; nd = 0; hi = 0; pd = 1'b0;
    while (busy && nb < 200) begin
      nb++;
      if (pd && (pwm_l || pwm_r)) hi++;
      pd = (dut.state == ST_DEAD);
      if (pd) nd++;
      @(negedge clk);
    end
    if (pd && (pwm_l || pwm_r)) hi++;
    sb_pop(nb);
    sb_pop(nd);
    sb_pop(hi);
    sb_pop(int'(cmd_if.cmd_ready));
    exp_dirs("rev5", 0, 0);
    settle();
    exp_duty("rev5", 5);

    // Invalid direction code then a valid one
    sb_push("bad_fault", 1);
    send(4'b0011, 4'd9);
    @(negedge clk);
    sb_pop(int'(fault));
    settle();
    exp_duty("bad", 0);
    exp_dirs("bad", 0, 0);
    sb_push("good_fault", 0);
    send(DIR_FWD, 4'd2);
    @(negedge clk);
    sb_pop(int'(fault));
    wait_ready(200);
    settle();
    exp_duty("fwd2", 2);
    exp_dirs("fwd2", 1, 1);

    // Command held while not ready is taken only once ready returns
    send(DIR_REV, 4'd4);
    cmd_if.dir_i     = DIR_LEFT;
    cmd_if.speed_i   = 4'd3;
    cmd_if.cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    sb_push("hold_ready", 1);
    sb_push("hold_busy", 0);
    sb_pop(int'(cmd_if.cmd_ready));
    sb_pop(int'(busy));
    exp_dirs("hold_pre", 0, 0);
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    sb_push("hold_acc_ready", 0);
    sb_push("hold_acc_busy", 1);
    @(negedge clk);
    sb_pop(int'(cmd_if.cmd_ready));
    sb_pop(int'(busy));
    wait_ready(200);
    settle();
    exp_dirs("left3", 0, 1);
    exp_duty("left3", 3);

    // Reset in the middle of the dead time
    send(DIR_FWD, 4'd6);
    n = 0;
    while (dut.state != ST_DEAD && n < 200) begin
      @(negedge clk);
      n++;
    end
    sb_push("dead_reached", int'(ST_DEAD));
    sb_pop(int'(dut.state));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_reset_vals("rst_dead");
    @(negedge clk);
    rst = 1'b1;

    // Speed on the cycle after acceptance
    sb_push("step_spd", SOFT ? 0 : 8);
    send(DIR_FWD, 4'd8);
    sb_pop(int'(dut.cur_spd));

    check("sb_leftover", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_drv.md
MOTOR_DRV -- requirements
Module: motor_drv

Interface
REQ-001 SHALL have parameter PRESC, default 4: clocks per PWM counter step (>=1).
REQ-002 SHALL have parameter RAMP_CYC, default 16: clocks per 1-step speed change (>=1).
REQ-003 SHALL have parameter DEAD_CYC, default 8: clocks of all-off dead time on wheel reversal (>=1).
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1: command (speed_i/dir_i) presented.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port speed_i, input, 4: target speed 0..15.
REQ-009 SHALL have port dir_i, input, 4: one-hot direction, 0001 fwd, 0010 rev, 0100 left, 1000 right, 0000 stop.
REQ-010 SHALL have ports pwm_l / pwm_r, output, 1 each: left/right wheel PWM.
REQ-011 SHALL have ports dir_l / dir_r, output, 1 each: wheel direction, 1 = forward.
REQ-012 SHALL have port busy, output, 1: reversal sequence in progress.
REQ-013 SHALL have port fault, output, 1: last accepted dir_i code invalid.

Function
REQ-014 Wheel mapping SHALL be: fwd l=1,r=1; rev l=0,r=0; left l=0,r=1; right l=1,r=0; stop/invalid keep current bits, target speed 0.
REQ-015 FSM states SHALL be IDLE, RUN, RAMP_DN, DEAD; cmd_ready=1 in IDLE/RUN, 0 in RAMP_DN/DEAD; busy = state in {RAMP_DN, DEAD}.
REQ-016 Accept in IDLE/RUN: if new wheel bits equal current, latch target speed, go/stay RUN; else latch pending dir+speed, go RAMP_DN (cur_spd>0) or DEAD (cur_spd==0).
REQ-017 RUN: cur_spd SHALL move 1 step toward target every RAMP_CYC clocks; RUN -> IDLE when cur_spd==0 and target==0.
REQ-018 RAMP_DN: cur_spd SHALL decrement every RAMP_CYC clocks; at 0 -> DEAD.
REQ-019 DEAD: pwm_l=pwm_r=0 for exactly DEAD_CYC clocks, then apply pending wheel bits, target=pending speed, -> RUN.
REQ-020 PWM: 4-bit counter cnt increments every PRESC clocks, wraps 15->0; pwm = (cur_spd > cnt), both wheels same cur_spd; duty = cur_spd/16, 15 -> 15/16, 0 -> never high.
REQ-021 Invalid dir_i (not one-hot, not 0000) SHALL be accepted, set fault=1, target 0; fault clears on next accepted valid code.
REQ-022 Command held with cmd_ready=0 SHALL NOT be latched; it is accepted on the first cycle ready returns.

Reset
REQ-023 rst=0 at a clock edge SHALL force state IDLE, cur_spd=0, target=0, cnt=0, prescale/ramp/dead counters 0, pwm_l=pwm_r=0, dir_l=dir_r=1, busy=0, fault=0, in any state including mid-reversal.
REQ-024 cmd_ready SHALL be 1 in the first cycle after rst returns high.

Configuration
REQ-025 Macro MOTOR_SOFT_RAMP_EN defined: ramping per REQ-017/018.
REQ-026 Macro undefined: cur_spd SHALL equal target on the cycle after acceptance, RAMP_DN is skipped (reversal goes straight to DEAD), dead time still applies.

Structure
REQ-027 Package motor_pkg SHALL hold dir code constants, state enum typedef, speed width constant (4).
REQ-028 Sub-module pwm_gen (prescaler + counter + compare) SHALL be instanced once, shared counter feeding both wheel compares.

Verification (PRESC=1, RAMP_CYC=2, DEAD_CYC=4, macro defined)
REQ-029 Reset, cmd fwd speed 8 -> dir_l=dir_r=1, cur_spd reaches 8 after 16 clocks, pwm_l high 8 of every 16 clocks.
REQ-030 Speed 15 fwd settled -> pwm high 15/16; speed 0 -> pwm never high, state IDLE.
REQ-031 At speed 8 fwd, cmd rev 5 -> ready=0, busy=1, ramp to 0 in 16 clocks, pwm low 4 clocks, dir bits 0, ramp to 5, ready=1.
REQ-032 dir_i=0011 accepted -> fault=1, speed ramps to 0; then dir_i=0001 -> fault=0.
REQ-033 cmd_valid held during DEAD with left 3 -> not latched until ready=1, then accepted one cycle later.
REQ-034 rst=0 during DEAD -> next cycle all outputs at REQ-023 values; macro undefined -> speed 8 cmd gives cur_spd=8 next cycle.
